// File: rtl/mem_array_pkg.sv
// mem_array_pkg: shared definitions for the mem_array register file.
//   - state_t     : bulk-clear FSM encoding (IDLE, CLEAR)
//   - DEF_WIDTH   : default data bits per row
//   - DEF_DEPTH   : default number of rows
//   - even_parity : parity bit that makes {data, parity} have an even count of ones
// Optional feature macro used by the files importing this package: PARITY_EN.
package mem_array_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_DEPTH = 16;

    // Widest row the parity helper accepts; narrower rows are zero-extended,
    // which leaves the XOR reduction unchanged.
    localparam int MAX_WIDTH = 64;

    function automatic logic even_parity(input logic [MAX_WIDTH-1:0] v);
        return ^v;
    endfunction

endpackage

// File: rtl/mem_array_row.sv
// mem_row: one storage row of the mem_array register file.
// Ports:
//   ck, rst_n : clock, asynchronous active-low reset (row goes to 0)
//   we        : load d on the rising edge
//   clr       : synchronous clear to 0; wins over we
//   d         : write data
//   q         : stored data
//   p_d, p    : stored parity bit in/out (only when PARITY_EN is defined)
module mem_row
    import mem_array_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             ck,
    input  logic             rst_n,
    input  logic             we,
    input  logic             clr,
    input  logic [WIDTH-1:0] d,
`ifdef PARITY_EN
    input  logic             p_d,
    output logic             p,
`endif
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge ck or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
`ifdef PARITY_EN
            p <= 1'b0;
`endif
        end else if (clr) begin
            // All-zero data with parity 0 is a valid even-parity row.
            q <= '0;
`ifdef PARITY_EN
            p <= 1'b0;
`endif
        end else if (we) begin
            q <= d;
`ifdef PARITY_EN
            p <= p_d;
`endif
        end
    end

endmodule

// File: rtl/mem_array.sv
// mem_array: WIDTH x DEPTH register file with registered read port and a
// sequential bulk-clear engine.
// Ports:
//   ck, rst_n : clock, asynchronous active-low reset
//   addr      : row address for read and write
//   d, wr     : write data and write strobe (0-cycle write latency)
//   rd        : read strobe; q/q_valid update one cycle later
//   clr       : start a bulk clear (ignored while one is running)
//   inj_err   : invert stored parity on a write (PARITY_EN only)
//   q         : registered read data, holds until the next accepted read
//   q_valid   : one-cycle pulse per accepted read
//   busy      : bulk clear in progress (exactly DEPTH cycles)
//   par_err   : parity mismatch of the row behind q (0 without PARITY_EN)
// Build option: define PARITY_EN to add one even-parity bit per row.
//
// Strobe semantics: there is no back-pressure. A rd/wr is accepted in the
// cycle it is sampled when busy=0, and dropped when busy=1. Every accepted
// rd produces exactly one q_valid pulse on the following cycle.
module mem_array
    import mem_array_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             ck,
    input  logic             rst_n,
    input  logic [AW-1:0]    addr,
    input  logic [WIDTH-1:0] d,
    input  logic             wr,
    input  logic             rd,
    input  logic             clr,
    input  logic             inj_err,
    output logic [WIDTH-1:0] q,
    output logic             q_valid,
    output logic             busy,
    output logic             par_err
);

    state_t          state;
    logic [AW-1:0]   ptr;
    logic            addr_ok;
    logic [WIDTH-1:0] rd_data;
    logic [WIDTH-1:0] row_q [DEPTH];
    logic [DEPTH-1:0] row_we;
    logic [DEPTH-1:0] row_clr;

    // DEPTH need not be a power of two, so the top of the address space can
    // be unpopulated.
    assign addr_ok = (32'(addr) < 32'(DEPTH));
    assign rd_data = addr_ok ? row_q[addr] : '0;

`ifdef PARITY_EN
    logic             row_p [DEPTH];
    logic             wr_par;
    logic             rd_perr;
    logic             par_err_r;

    assign wr_par  = even_parity(MAX_WIDTH'(d)) ^ inj_err;
    // Out-of-range reads return zero data with zero parity: no error.
    assign rd_perr = addr_ok ? (even_parity(MAX_WIDTH'(row_q[addr])) ^ row_p[addr]) : 1'b0;
    assign par_err = par_err_r;
`else
    logic unused_inj;
    assign unused_inj = inj_err;
    assign par_err    = 1'b0;
`endif

    for (genvar i = 0; i < DEPTH; i++) begin : g_row
        assign row_we[i]  = (state == IDLE) && wr && addr_ok && (addr == AW'(i));
        assign row_clr[i] = (state == CLEAR) && (ptr == AW'(i));

        mem_row #(.WIDTH(WIDTH)) u_row (
            .ck    (ck),
            .rst_n (rst_n),
            .we    (row_we[i]),
            .clr   (row_clr[i]),
            .d     (d),
`ifdef PARITY_EN
            .p_d   (wr_par),
            .p     (row_p[i]),
`endif
            .q     (row_q[i])
        );
    end

    // Reads sample the row before this edge's write lands, which gives
    // read-first behaviour for a same-address rd+wr.
    always_ff @(posedge ck or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            ptr     <= '0;
            q       <= '0;
            q_valid <= 1'b0;
            busy    <= 1'b0;
`ifdef PARITY_EN
            par_err_r <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    q_valid <= rd;
                    if (rd) begin
                        q <= rd_data;
`ifdef PARITY_EN
                        par_err_r <= rd_perr;
`endif
                    end
                    if (clr) begin
                        state <= CLEAR;
                        busy  <= 1'b1;
                        ptr   <= '0;
                    end
                end
                CLEAR: begin
                    q_valid <= 1'b0;
                    if (ptr == AW'(DEPTH - 1)) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        ptr   <= '0;
                    end else begin
                        ptr <= ptr + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    ptr   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_array.sv
// tb_mem_array: directed bench for mem_array at WIDTH=8, DEPTH=16.
module tb_mem_array;

    localparam int W  = 8;
    localparam int DP = 16;
    localparam int A  = 4;

`ifdef PARITY_EN
    localparam bit PAR_ON = 1'b1;
`else
    localparam bit PAR_ON = 1'b0;
`endif

    logic         ck;
    logic         rst_n;
    logic [A-1:0] addr;
    logic [W-1:0] d;
    logic         wr, rd, clr, inj_err;
    logic [W-1:0] q;
    logic         q_valid, busy, par_err;

    int total = 0;
    int bad   = 0;

    logic [W-1:0] mdl [DP];
    logic [W-1:0] exp_q;

    mem_array #(.WIDTH(W), .DEPTH(DP)) dut (
        .ck      (ck),
        .rst_n   (rst_n),
        .addr    (addr),
        .d       (d),
        .wr      (wr),
        .rd      (rd),
        .clr     (clr),
        .inj_err (inj_err),
        .q       (q),
        .q_valid (q_valid),
        .busy    (busy),
        .par_err (par_err)
    );

    // clock / reset
    initial ck = 1'b0;
    always #5 ck = ~ck;

    typedef struct {
        string        name;
        bit           rd;
        bit           wr;
        bit           inj;
        logic [A-1:0] addr;
        logic [W-1:0] d;
        logic [W-1:0] eq;
        bit           eqv;
        bit           epe;
    } vec_t;

    function automatic vec_t mk(string n, bit r, bit w, bit ij, logic [A-1:0] a,
                                logic [W-1:0] dd, logic [W-1:0] e_q, bit e_qv, bit e_pe);
        vec_t v;
        v.name = n; v.rd = r; v.wr = w; v.inj = ij; v.addr = a; v.d = dd;
        v.eq = e_q; v.eqv = e_qv; v.epe = e_pe;
        return v;
    endfunction

    task automatic check(input string n, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", n, act, exp);
        end
    endtask

    // driver: apply inputs after the previous edge, then step one edge and
    // land 1 time unit past it for sampling.
    task automatic tick(input bit r, input bit w, input bit c, input logic [A-1:0] a,
                        input logic [W-1:0] dd, input bit ij);
        rd = r; wr = w; clr = c; addr = a; d = dd; inj_err = ij;
        @(posedge ck);
        #1;
    endtask

    task automatic idle();
        tick(1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
    endtask

    task automatic read_all_zero(input string tag);
        for (int i = 0; i < DP; i++) begin
            tick(1'b1, 1'b0, 1'b0, A'(i), '0, 1'b0);
            check({tag, "_q"}, q, 0);
            check({tag, "_qv"}, q_valid, 1);
            check({tag, "_pe"}, par_err, 0);
        end
        idle();
        check({tag, "_qv_drop"}, q_valid, 0);
        exp_q = '0;
        for (int i = 0; i < DP; i++) mdl[i] = '0;
    endtask

    task automatic fill_rows(input logic [W-1:0] base);
        for (int i = 0; i < DP; i++) begin
            mdl[i] = base + W'(i * 17 + 1);
            tick(1'b0, 1'b1, 1'b0, A'(i), mdl[i], 1'b0);
        end
    endtask

    vec_t vecs[$];
    int   busy_cnt;

    initial begin
        rst_n = 1'b0;
        rd = 0; wr = 0; clr = 0; addr = '0; d = '0; inj_err = 0;
        exp_q = '0;
        repeat (3) @(posedge ck);
        #1;
        check("rst_q", q, 0);
        check("rst_qv", q_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_pe", par_err, 0);
        rst_n = 1'b1;
        idle();

        read_all_zero("init");

        // name, rd, wr, inj, addr, d, exp q, exp q_valid, exp par_err
        vecs.push_back(mk("wr3",      0, 1, 0, 4'd3, 8'hA5, 8'h00, 0, 0));
        vecs.push_back(mk("rd3",      1, 0, 0, 4'd3, 8'h00, 8'hA5, 1, 0));
        vecs.push_back(mk("hold3",    0, 0, 0, 4'd0, 8'h00, 8'hA5, 0, 0));
        vecs.push_back(mk("wr5_old",  0, 1, 0, 4'd5, 8'h11, 8'hA5, 0, 0));
        vecs.push_back(mk("rdwr5",    1, 1, 0, 4'd5, 8'h3C, 8'h11, 1, 0));
        vecs.push_back(mk("rd5_new",  1, 0, 0, 4'd5, 8'h00, 8'h3C, 1, 0));
        vecs.push_back(mk("hold5",    0, 0, 0, 4'd0, 8'h00, 8'h3C, 0, 0));
        vecs.push_back(mk("wr2_inj",  0, 1, 1, 4'd2, 8'h0F, 8'h3C, 0, 0));
        vecs.push_back(mk("rd2_inj",  1, 0, 0, 4'd2, 8'h00, 8'h0F, 1, PAR_ON));
        vecs.push_back(mk("wr2_fix",  0, 1, 0, 4'd2, 8'h0F, 8'h0F, 0, PAR_ON));
        vecs.push_back(mk("rd2_fix",  1, 0, 0, 4'd2, 8'h00, 8'h0F, 1, 0));
        vecs.push_back(mk("rd3_b2b",  1, 0, 0, 4'd3, 8'h00, 8'hA5, 1, 0));
        vecs.push_back(mk("wr9_odd",  0, 1, 0, 4'd9, 8'h07, 8'hA5, 0, 0));
        vecs.push_back(mk("rd9_odd",  1, 0, 0, 4'd9, 8'h00, 8'h07, 1, 0));
        vecs.push_back(mk("idle_end", 0, 0, 0, 4'd0, 8'h00, 8'h07, 0, 0));

        foreach (vecs[i]) begin
            tick(vecs[i].rd, vecs[i].wr, 1'b0, vecs[i].addr, vecs[i].d, vecs[i].inj);
            check({vecs[i].name, "_q"}, q, vecs[i].eq);
            check({vecs[i].name, "_qv"}, q_valid, vecs[i].eqv);
            check({vecs[i].name, "_pe"}, par_err, vecs[i].epe);
            check({vecs[i].name, "_busy"}, busy, 0);
        end
        exp_q = 8'h07;

        // bulk clear with rd/wr/clr hammered while busy
        fill_rows(8'h20);
        tick(1'b0, 1'b0, 1'b1, '0, '0, 1'b0);
        check("clr_busy_rise", busy, 1);
        busy_cnt = 1;
        for (int n = 0; n < 40; n++) begin
            if (!busy) break;
            tick(1'b1, 1'b1, 1'b1, A'($urandom_range(0, DP - 1)), 8'hFF, 1'b0);
            check("clr_qv_low", q_valid, 0);
            check("clr_q_hold", q, exp_q);
            if (busy) busy_cnt++;
        end
        check("clr_busy_cycles", busy_cnt, DP);
        idle();
        check("clr_busy_end", busy, 0);
        read_all_zero("after_clr");

        // clr together with rd in IDLE, then reset in the middle of the clear
        fill_rows(8'h40);
        tick(1'b1, 1'b0, 1'b1, 4'd3, '0, 1'b0);
        check("clr_rd_qv", q_valid, 1);
        check("clr_rd_q", q, mdl[3]);
        check("clr_rd_busy", busy, 1);
        repeat (7) idle();
        check("midclr_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        check("midclr_rst_busy", busy, 0);
        check("midclr_rst_q", q, 0);
        check("midclr_rst_qv", q_valid, 0);
        check("midclr_rst_pe", par_err, 0);
        @(posedge ck);
        #1;
        rst_n = 1'b1;
        idle();
        check("post_rst_idle", busy, 0);
        read_all_zero("after_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mem_array.md
# mem_array

Parametrised register-file memory built from WIDTH-bit rows, DEPTH rows deep.
- Decodes a row address, writes on `wr`, and returns read data through a registered output with a valid strobe.
- Provides a sequential bulk-clear engine.
- Sits between the datapath controller and the row storage, as the next-generation replacement for single fixed-width 3-bit rows.

## Interface
Parameters:
- WIDTH, 8, data bits per row
- DEPTH, 16, number of rows (need not be a power of two; minimum 2)
- AW, $clog2(DEPTH), address width (derived; do not override)

Ports:
- ck  input  1  clock; all state changes on the rising edge
- rst_n  input  1  reset, asynchronous, active-low
- addr  input  AW  row address for read and write
- d  input  WIDTH  write data
- wr  input  1  write strobe
- rd  input  1  read strobe
- clr  input  1  start bulk clear
- inj_err  input  1  parity fault-injection control (see Configuration)
- q  output  WIDTH  registered read data
- q_valid  output  1  one-cycle pulse marking a new value on q
- busy  output  1  bulk clear in progress
- par_err  output  1  parity mismatch on the current read (see Configuration)

## Operation
- Reset (rst_n=0): all rows, q, q_valid, busy, par_err and the clear pointer go to 0, and the FSM goes to IDLE.
- FSM states:
  - IDLE → CLEAR on clr=1.
  - CLEAR → IDLE after the row with pointer value DEPTH-1 is cleared.
  - clr is ignored while in CLEAR.
- In IDLE:
  - wr=1 and addr<DEPTH: row[addr] takes d at the edge.
  - rd=1: q takes row[addr] and q_valid=1 on the next cycle.
  - rd=1 and addr≥DEPTH: q=0 with q_valid=1.
  - wr=1 and addr≥DEPTH: the write is dropped.
- Simultaneous rd and wr to the same address: read-first. q returns the old contents and the row holds the new data afterwards.
- clr together with rd or wr in IDLE: the read and write are still performed that cycle, then CLEAR starts on the next cycle.
- In CLEAR:
  - Each cycle zeroes row[ptr], then ptr increments.
  - busy=1 for exactly DEPTH cycles.
  - rd and wr are ignored, and q_valid stays 0.
- q holds its last read value until the next accepted read; bulk clear does not change q.
- Reset during CLEAR aborts the clear immediately; all rows are 0 by reset regardless.

## Timing
- Write latency: 0 cycles. Data written at edge N is readable by a read issued at N+1.
- Read latency: 1 cycle. rd sampled at edge N gives q/q_valid valid after edge N+1.
- Clear: busy rises at the edge that samples clr and falls DEPTH edges later.
  - The first rd/wr accepted after a clear is the one sampled with busy=0.
- q_valid is never high for two consecutive cycles unless rd is high on consecutive accepted cycles.

## Configuration
- PARITY_EN defined:
  - Each row stores one extra even-parity bit, computed from d on write.
  - If inj_err=1 during a write, the stored parity is inverted.
  - par_err is registered alongside q and is 1 when the read row's parity mismatches its data.
  - Bulk clear and reset write valid parity (0).
- PARITY_EN undefined:
  - No parity storage.
  - par_err is tied to 0 and inj_err is ignored.

## Structure
- Package mem_array_pkg holds:
  - the FSM state encoding (IDLE, CLEAR);
  - default WIDTH/DEPTH constants;
  - the parity function.
- Sub-module mem_row: one storage row (WIDTH data bits, plus a parity bit under PARITY_EN) with write-enable and synchronous clear inputs.
  - Instantiated DEPTH times by a generate loop.
  - mem_array owns decode, the read mux and the FSM.

## Test plan
- Reset, then read addr 0..DEPTH-1 → every q=0x00 with q_valid pulsing once per read and par_err=0.
- Write 0xA5 to addr 3, read addr 3 next cycle → q=0xA5 one cycle after rd, q_valid=1 for that one cycle.
- Same cycle wr addr 5 d=0x3C and rd addr 5 over old value 0x11 → q=0x11; a following read → q=0x3C.
- Fill all rows, pulse clr with DEPTH=16 → busy high 16 cycles; rd/wr issued while busy produce no q_valid and no writes; all reads after busy falls return 0x00.
- Assert rst_n=0 mid-clear (ptr=7) → busy=0 and q=0 immediately; FSM in IDLE; all rows read 0.
- PARITY_EN: write 0x0F with inj_err=1 to addr 2, then read → q=0x0F, par_err=1. A rewrite with inj_err=0 then read → par_err=0. Without the macro, par_err stays 0 throughout.
